mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 single-bit data mux among four requesters. It grants one requester at a time, holds the grant while that requester keeps its request asserted, and drives the mux select from the registered grant. It sits between the requesting agents and the mux datapath, and is the only block that drives the mux select.

## Interface
Parameters:
- MAX_HOLD, 8: maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  4  request per agent; level-sensitive; agent i holds req[i] high for its whole transfer
- data  in  4  data bit per agent; data[i] belongs to agent i
- gnt  out  4  one-hot grant, registered; all zero when idle
- sel  out  2  registered mux select; equals the index of the set bit of gnt while busy; holds its last value when idle
- busy  out  1  registered; high exactly when gnt != 0
- data_out  out  1  combinational; equals data[sel] when busy, 0 otherwise
- timeout  out  1  registered one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN

## Operation
- State machine: IDLE (2'b00) and GRANT (2'b01). No other states are reachable.
- Rotating priority pointer ptr[1:0]: agent ptr has highest priority, then ptr+1, ptr+2 and ptr+3, all mod 4.
- IDLE, req == 0: stay in IDLE; outputs unchanged.
- IDLE, req != 0: winner w is the first set bit of req, searching from ptr upward with wrap. On the clock edge:
  - gnt <= 1<<w; sel <= w; busy <= 1; ptr <= w+1 (mod 4); state <= GRANT.
- GRANT, req[sel] == 1: hold gnt, sel and ptr unchanged. Requests from other agents are ignored.
- GRANT, req[sel] == 0: on the clock edge, gnt <= 0, busy <= 0, state <= IDLE; sel keeps its value.
- Every grant is followed by at least one IDLE cycle before the next grant. Back-to-back grants are not allowed.
- Requests that fall before being granted are simply not served; no request is latched.
- Reset mid-grant: on the next clock edge gnt is cleared with no drain. The owner must tolerate losing its grant.
- Reset values: state=IDLE, gnt=0, sel=0, busy=0, timeout=0, ptr=0, hold counter=0.

## Timing
- Request-to-grant latency: 1 cycle. If req rises before edge N while in IDLE, gnt is valid after edge N.
- Release latency: 1 cycle. If req[owner] falls before edge M, gnt is 0 after edge M.
- Minimum cycle from one grant to the next: grant, 1 idle cycle, then the next grant.
- data_out has zero latency from data and follows the registered sel.
- Simultaneous requests: exactly one winner, chosen per the ptr order. Under continuous contention, each agent is served at least once every 4 grants.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and req[owner] is still high, the next edge forces a release (gnt <= 0, state <= IDLE) and sets timeout <= 1 for one cycle.
  - Because ptr already points past the owner, the timed-out agent has lowest priority at the next arbitration.
  - A normal release on the same cycle as the limit counts as normal: timeout stays 0.
- Undefined: no counter; grants are unbounded; timeout is a constant 0.

## Structure
- Package mux_arb_pkg:
  - state type with IDLE and GRANT;
  - NUM_REQ = 4;
  - SEL_W = 2;
  - HOLD_CNT_W = 8.
- Sub-module rr_pick: purely combinational; inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0]. It holds the rotate-and-priority logic. The top module holds the FSM, the registers, the counter and the data mux.

## Test plan
- Reset with req=4'b1111, then release reset: gnt=4'b0001, sel=0 one cycle later; ptr=1.
- req=4'b1111 held, with each owner dropping its req after 3 cycles and re-raising it 1 cycle later: grant order 0,1,2,3,0, each grant separated by one idle cycle.
- req=4'b0100 only, data=4'b0100: busy=1, sel=2, data_out=1. When req drops: gnt=0 and data_out=0 on the next cycle.
- reset asserted while gnt=4'b0010: gnt=0, busy=0, sel=0 one cycle later; IDLE after reset deasserts.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 constant:
  - agent 0 is granted for 4 cycles, then gnt=0 with timeout=1 for one cycle;
  - next grant goes to agent 1.
- Without ARB_TIMEOUT_EN, req[0] held for 300 cycles: gnt=4'b0001 throughout and timeout stays 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the round-robin mux arbiter.
// No logic; latency n/a.
// Backpressure n/a.
package mux_arb_pkg;

    localparam int NUM_REQ    = 4;
    localparam int SEL_W      = 2;
    localparam int HOLD_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when no request is pending.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 data mux select; optional grant limit under ARB_TIMEOUT_EN.
// Latency: request-to-grant 1 cycle, release 1 cycle, one idle cycle between grants; data_out 0 cycles.
// Backpressure: grant held while owner keeps req high; unserved requests are not latched.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               data_out,
    output logic               timeout
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(MAX_HOLD - 1);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic               busy_d;
    logic               timeout_d;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] hold_q, hold_d;
`else
    logic unused_hold_limit;
    assign unused_hold_limit = ^HOLD_LIMIT;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt;
        sel_d     = sel;
        busy_d    = busy;
        timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    // Owner drops to lowest priority for the next arbitration.
                    ptr_d   = pick_idx + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LIMIT) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt     <= gnt_d;
            sel     <= sel_d;
            busy    <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q  <= '0;
            timeout <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            timeout <= timeout_d;
        end
    end
`else
    logic unused_timeout_d;
    assign unused_timeout_d = timeout_d;
    assign timeout          = 1'b0;
`endif

    assign data_out = busy ? data[sel] : 1'b0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mux_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int MH    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MH    = 8;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'h0;
    logic [3:0] data  = 4'h0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       data_out;
    logic       timeout;

    mux_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data     (data),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .data_out (data_out),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: owner index (-1 when idle), priority pointer, last select.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;
    int cand;
    logic [31:0] e_gnt;
    logic [31:0] e_dout;

    always begin
        @(posedge clk);
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 4; k++) begin
                cand = (m_ptr + k) % 4;
                if (req[cand]) begin
                    m_owner = cand;
                    m_sel   = cand;
                    m_ptr   = (cand + 1) % 4;
                    m_hold  = 0;
                    break;
                end
            end
        end else begin
            m_to = 1'b0;
            if (!req[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_hold == MH - 1) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_hold++;
            end
        end
        #1;
        e_gnt  = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        e_dout = (m_owner < 0) ? 32'd0 : 32'(data[m_sel]);
        check("model_gnt", 32'(gnt), e_gnt);
        check("model_sel", 32'(sel), 32'(m_sel));
        check("model_busy", 32'(busy), 32'(m_owner >= 0));
        check("model_data_out", 32'(data_out), e_dout);
        check("model_timeout", 32'(timeout), 32'(m_to));
    end

    task automatic wait_busy(input string name);
        int t = 0;
        while (busy !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(busy), 32'd1);
    endtask

    initial begin
        int own;
        int held;

        // Reset with all agents requesting.
        reset = 1'b1; req = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;

        // Contention: each owner keeps req 3 cycles, drops for 1, re-raises.
        for (int g = 0; g < 5; g++) begin
            own = g % 4;
            wait_busy("order_wait");
            check("order_sel", 32'(sel), 32'(own));
            check("order_gnt", 32'(gnt), 32'd1 << own);
            repeat (2) @(negedge clk);
            req[own] = 1'b0;
            @(negedge clk);
            check("order_idle_gap", 32'(busy), 32'd0);
            req[own] = 1'b1;
        end
        req = 4'h0;
        @(negedge clk);

        // Single requester with data through the mux.
        req = 4'b0100; data = 4'b0100;
        @(negedge clk);
        check("single_busy", 32'(busy), 32'd1);
        check("single_sel", 32'(sel), 32'd2);
        check("single_dout", 32'(data_out), 32'd1);
        req = 4'h0;
        @(negedge clk);
        check("single_rel_gnt", 32'(gnt), 32'd0);
        check("single_rel_dout", 32'(data_out), 32'd0);
        check("single_rel_sel", 32'(sel), 32'd2);

        // Reset while agent 1 owns the grant.
        req = 4'b0010;
        @(negedge clk);
        check("midrst_pre_gnt", 32'(gnt), 32'b0010);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sel", 32'(sel), 32'd0);
        reset = 1'b0; req = 4'h0;
        @(negedge clk);
        check("midrst_idle", 32'(busy), 32'd0);

        // Randomized traffic with sticky requests and rare resets.
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) req[b] = ~req[b];
            data  = 4'($urandom);
            reset = ($urandom_range(199) == 0);
            @(negedge clk);
        end

        reset = 1'b1; req = 4'h0;
        @(negedge clk);
        reset = 1'b0;
`ifdef ARB_TIMEOUT_EN
        req = 4'b0011;
        @(negedge clk);
        held = 0;
        while (gnt === 4'b0001 && held < 20) begin
            held++;
            @(negedge clk);
        end
        check("to_hold_len", 32'(held), 32'd4);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_rel_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        check("to_pulse_end", 32'(timeout), 32'd0);
        check("to_next_gnt", 32'(gnt), 32'b0010);
`else
        held = 0;
        req = 4'b0001;
        @(negedge clk);
        for (int c = 0; c < 300; c++) begin
            check("long_gnt", 32'(gnt), 32'd1);
            check("long_timeout", 32'(timeout), 32'd0);
            @(negedge clk);
        end
`endif
        req = 4'h0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
